uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
- WISHBONE master that owns the MiniUART slave port and sequences every access to it.
- At reset it programs both baud divisors, then polls LSR.
- Drains received bytes to a single sink.
- Shares the transmitter between two byte requesters under round-robin arbitration.
- Sits between the bridge/peripheral side and the MiniUART, so no other agent touches the UART bus.

Parameters:
- DIVR_INIT, 16'd2604: RX divisor written at init (9600 baud at 25 MHz).
- DIVT_INIT, 16'd2604: TX divisor written at init.
- TX_GUARD, 2: idle cycles after a DATA write before LSR is polled again; covers the tx load-to-busy delay.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset.
- ADD_O  out  3  UART register address [4:2].
- DAT_O  out  32  write data to UART.
- DAT_I  in  32  read data from UART.
- STB_O  out  1  bus strobe.
- WE_O  out  1  bus write enable.
- ACK_I  in  1  bus acknowledge.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req1_valid / req1_data / req1_ready: same for requester 1.
- rx_valid  out  1  received byte held for the sink.
- rx_data  out  8  received byte.
- rx_ready  in  1  sink accepts rx_data.
- init_done  out  1  divisors programmed.

Behaviour:
- Clock and reset: one clock, CLK_I; reset RST_I is asynchronous and active-high.
- Reset values:
  - state=INIT_DIVR.
  - STB_O=0, WE_O=0, ADD_O=0, DAT_O=0.
  - req0_ready=0, req1_ready=0.
  - rx_valid=0, rx_data=0, init_done=0.
  - last_grant=1, so req0 wins first.
- Bus outputs are decoded from the registered state, with STB_O=0 in GUARD.
- Every bus state holds STB_O/WE_O/ADD_O/DAT_O until ACK_I=1 and advances on that edge.
- MiniUART acks in the same cycle, so each access takes 1 cycle.
- States:
  - INIT_DIVR: write ADD=OFF_DIVR, DAT={16'b0,DIVR_INIT} -> INIT_DIVT.
  - INIT_DIVT: write ADD=OFF_DIVT, DAT={16'b0,DIVT_INIT} -> POLL; init_done set to 1 on exit and stays 1.
  - POLL: read ADD=OFF_LSR; on ACK sample ts=DAT_I[5] and rs=DAT_I[0]. Priority on that edge:
    - (a) rs=1 and rx_valid=0 -> RX_RD.
    - (b) rs=1 and rx_valid=1 -> stay POLL. No write of any kind may be issued, because any UART write clears rs and would drop the byte.
    - (c) rs=0, ts=1, some reqN_valid -> grant, latch byte, pulse reqN_ready for exactly this cycle -> TX_WR.
    - (d) otherwise -> stay POLL.
  - Arbitration: if both requesters are valid, grant !last_grant; a single valid requester always wins. last_grant updates on each grant.
  - RX_RD: read ADD=OFF_DATA; on ACK, rx_data<=DAT_I[7:0] -> RX_CLR.
  - RX_CLR: write ADD=OFF_LSR, DAT=0 (no register effect, clears rs); rx_valid<=1 on ACK -> POLL.
  - TX_WR: write ADD=OFF_DATA, DAT={24'b0,byte} -> GUARD.
  - GUARD: count TX_GUARD cycles -> POLL. A TX_GUARD of 0 goes directly to POLL.
- RX sink: rx_valid clears on the cycle rx_valid&rx_ready. Clearing has priority-free coexistence with POLL; only RX_CLR sets rx_valid.
- Request data is sampled only at the grant edge. Requesters must hold valid/data until ready.
- Async reset mid-access drops STB_O immediately; the sequence restarts from INIT_DIVR, and any latched TX/RX byte is discarded.
- ACK_I held low stalls in the current state indefinitely; no timeout.

Decomposition:
- Shared package/header `uart_ctrl_defs`: state encodings and UART offsets.
  - OFF_DATA=3'd0, OFF_LSR=3'd4, OFF_DIVR=3'd6, OFF_DIVT=3'd7.
  - LSR bit indices TS=5, RS=0.
  - Offset values must match the MiniUART's header.
- One natural sub-module, `rr_arb2`: 2-way round-robin grant with a last_grant register.
- FSM and bus drive stay in the top.

Test Plan:
- Reset release, ACK_I tied to STB_O -> exactly two writes: (7? no) ADD=6 DAT=2604, then ADD=7 DAT=2604; init_done=1 on cycle 2; then repeated LSR reads at ADD=4.
- LSR=0x20, req0_valid with 0x41 -> req0_ready pulses 1 cycle; next cycle write ADD=0 DAT=0x41; STB_O=0 for 2 cycles; then POLL.
- Both requesters valid continuously (0x11/0x22), ts=1 -> DATA writes alternate 0x11,0x22,0x11,0x22.
- LSR=0x21, req1_valid set, rx_valid=0 -> RX served first: read ADD=0 returns 0x5A; write ADD=4; rx_valid=1, rx_data=0x5A; TX only after the next poll with rs=0.
- rx_valid=1, rx_ready=0, LSR=0x21, req0_valid -> only LSR reads, zero writes; after rx_ready=1 the next byte is drained.
- Assert RST_I during TX_WR with ACK_I=0 -> STB_O drops without a clock edge; after release, INIT_DIVR write reappears and the pending byte is not sent.

Source files
------------

// File: rtl/uart_ctrl_defs.sv
// Shared definitions for the MiniUART host controller.
// Holds the controller state encoding, the MiniUART register offsets
// (ADD[4:2] word offsets) and the LSR status bit positions.
package uart_ctrl_defs;

  typedef enum logic [2:0] {
    S_INIT_DIVR = 3'd0,
    S_INIT_DIVT = 3'd1,
    S_POLL      = 3'd2,
    S_RX_RD     = 3'd3,
    S_RX_CLR    = 3'd4,
    S_TX_WR     = 3'd5,
    S_GUARD     = 3'd6
  } state_e;

  // Must track the MiniUART register map.
  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_LSR  = 3'd4;
  localparam logic [2:0] OFF_DIVR = 3'd6;
  localparam logic [2:0] OFF_DIVT = 3'd7;

  // LSR bits: transmitter idle and receive data available.
  localparam int LSR_TS = 5;
  localparam int LSR_RS = 0;

endpackage

// File: rtl/uart_host_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports: clk_i/rst_i (async active-high), req_i requests, take_i commits the
// current grant, gnt_o one-hot grant (combinational), any_o some request.
module rr_arb2
  (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o,
    output logic       any_o
  );

  logic last_q;
  logic last_d;

  // Contention goes to the requester that did not win last time; a lone
  // requester always wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  assign any_o = |req_i;

  always_comb begin
    last_d = last_q;
    if (take_i && any_o) begin
      last_d = gnt_o[1];
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// WISHBONE master owning the MiniUART: programs both divisors, then polls LSR,
// drains RX bytes to one sink and serves two TX requesters round-robin.
// Ports: CLK_I/RST_I, UART bus (ADD_O DAT_O DAT_I STB_O WE_O ACK_I),
// req0/req1 valid/data/ready, rx_valid/rx_data/rx_ready sink, init_done.
module uart_host_ctrl
  import uart_ctrl_defs::*;
  #(
    parameter logic [15:0] DIVR_INIT = 16'd2604,
    parameter logic [15:0] DIVT_INIT = 16'd2604,
    parameter int unsigned TX_GUARD  = 2
  )
  (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [2:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        init_done
  );

  localparam int unsigned GUARD_LAST_I = (TX_GUARD == 0) ? 0 : TX_GUARD - 1;
  localparam logic [7:0]  GUARD_LAST   = GUARD_LAST_I[7:0];

  state_e      state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  guard_q, guard_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        init_done_q, init_done_d;

  logic        stb, we;
  logic [2:0]  add;
  logic [31:0] dat;

  logic [1:0]  gnt;
  logic        arb_any;
  logic        lsr_ts, lsr_rs;
  logic        tx_take;

  assign lsr_ts = DAT_I[LSR_TS];
  assign lsr_rs = DAT_I[LSR_RS];

  // A TX grant only happens with no pending RX byte in the UART, so a write
  // can never clear rs while a received byte is still unread.
  assign tx_take = (state_q == S_POLL) && ACK_I && !lsr_rs && lsr_ts && arb_any;

  rr_arb2 u_arb (
    .clk_i  (CLK_I),
    .rst_i  (RST_I),
    .req_i  ({req1_valid, req0_valid}),
    .take_i (tx_take),
    .gnt_o  (gnt),
    .any_o  (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    guard_d     = guard_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    stb         = 1'b0;
    we          = 1'b0;
    add         = 3'd0;
    dat         = 32'd0;

    case (state_q)
      S_INIT_DIVR: begin
        stb = 1'b1;
        we  = 1'b1;
        add = OFF_DIVR;
        dat = {16'b0, DIVR_INIT};
        if (ACK_I) state_d = S_INIT_DIVT;
      end
      S_INIT_DIVT: begin
        stb = 1'b1;
        we  = 1'b1;
        add = OFF_DIVT;
        dat = {16'b0, DIVT_INIT};
        if (ACK_I) begin
          state_d     = S_POLL;
          init_done_d = 1'b1;
        end
      end
      S_POLL: begin
        stb = 1'b1;
        add = OFF_LSR;
        if (ACK_I) begin
          if (lsr_rs && !rx_valid_q) begin
            state_d = S_RX_RD;
          end else if (tx_take) begin
            tx_byte_d = gnt[1] ? req1_data : req0_data;
            state_d   = S_TX_WR;
          end
        end
      end
      S_RX_RD: begin
        stb = 1'b1;
        add = OFF_DATA;
        if (ACK_I) begin
          rx_data_d = DAT_I[7:0];
          state_d   = S_RX_CLR;
        end
      end
      S_RX_CLR: begin
        // Dummy LSR write: no register effect, but it clears rs.
        stb = 1'b1;
        we  = 1'b1;
        add = OFF_LSR;
        if (ACK_I) state_d = S_POLL;
      end
      S_TX_WR: begin
        stb = 1'b1;
        we  = 1'b1;
        add = OFF_DATA;
        dat = {24'b0, tx_byte_q};
        if (ACK_I) begin
          guard_d = 8'd0;
          state_d = (TX_GUARD == 0) ? S_POLL : S_GUARD;
        end
      end
      S_GUARD: begin
        // Bus idle while the transmitter turns busy, so the next poll
        // cannot see a stale ts=1.
        guard_d = guard_q + 8'd1;
        if (guard_q == GUARD_LAST) state_d = S_POLL;
      end
      default: state_d = S_INIT_DIVR;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if ((state_q == S_RX_CLR) && ACK_I) rx_valid_d = 1'b1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= S_INIT_DIVR;
      tx_byte_q   <= 8'd0;
      guard_q     <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_byte_q   <= tx_byte_d;
      guard_q     <= guard_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Bus drive is masked by reset so an access in flight is dropped without
  // waiting for a clock edge.
  assign STB_O      = stb & ~RST_I;
  assign WE_O       = we & ~RST_I;
  assign ADD_O      = RST_I ? 3'd0 : add;
  assign DAT_O      = RST_I ? 32'd0 : dat;
  assign req0_ready = tx_take & gnt[0];
  assign req1_ready = tx_take & gnt[1];
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-queue model of the expected bus traffic.
module tb_uart_host_ctrl;

  localparam int TXG = 2;

  localparam int K_POLL = 0;
  localparam int K_DIVR = 1;
  localparam int K_DIVT = 2;
  localparam int K_RD   = 3;
  localparam int K_CLR  = 4;
  localparam int K_TX   = 5;
  localparam int K_IDLE = 6;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } ent_t;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [2:0]  ADD_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data  = 8'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data  = 8'd0;
  logic        req1_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b1;
  logic        init_done;

  logic        ack_en = 1'b1;
  logic [7:0]  lsr    = 8'h00;
  logic [7:0]  rxb    = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK_I = ~CLK_I;

  // MiniUART slave: same-cycle ack (gateable to stall), DATA reads return
  // rxb, everything else returns the LSR image; upper bits are junk.
  assign ACK_I = STB_O & ack_en;
  assign DAT_I = (ADD_O == 3'd0) ? {24'hC0FFEE, rxb} : {24'hA5A5A5, lsr};

  uart_host_ctrl #(
    .DIVR_INIT (16'd2604),
    .DIVT_INIT (16'd2604),
    .TX_GUARD  (TXG)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .ADD_O      (ADD_O),
    .DAT_O      (DAT_O),
    .DAT_I      (DAT_I),
    .STB_O      (STB_O),
    .WE_O       (WE_O),
    .ACK_I      (ACK_I),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .init_done  (init_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending bus transactions the controller owes; an empty queue means it
  // is polling LSR.
  ent_t       q[$];
  int         m_last;
  logic       m_rx_valid;
  logic [7:0] m_rx_data;
  logic       m_init;

  task automatic model_reset();
    ent_t e;
    q.delete();
    e.b = 8'd0;
    e.kind = K_DIVR; q.push_back(e);
    e.kind = K_DIVT; q.push_back(e);
    m_last     = 1;
    m_rx_valid = 1'b0;
    m_rx_data  = 8'd0;
    m_init     = 1'b0;
  endtask

  task automatic bus_expect(input ent_t e, output logic s, output logic w,
                            output logic [2:0] a, output logic [31:0] d);
    s = 1'b1; w = 1'b0; a = 3'd0; d = 32'd0;
    case (e.kind)
      K_DIVR: begin w = 1'b1; a = 3'd6; d = 32'd2604; end
      K_DIVT: begin w = 1'b1; a = 3'd7; d = 32'd2604; end
      K_POLL: begin a = 3'd4; end
      K_RD:   begin a = 3'd0; end
      K_CLR:  begin w = 1'b1; a = 3'd4; d = 32'd0; end
      K_TX:   begin w = 1'b1; a = 3'd0; d = {24'd0, e.b}; end
      default: s = 1'b0;
    endcase
  endtask

  always @(negedge CLK_I) begin
    ent_t       cur, e;
    logic       es, ew, ack, set_rx, e_r0, e_r1;
    logic [2:0] ea;
    logic [31:0] ed;
    int         g;
    if (RST_I) begin
      model_reset();
      chk("rst_stb", {31'd0, STB_O}, 32'd0);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
    end else begin
      if (q.size() == 0) begin
        cur.kind = K_POLL; cur.b = 8'd0;
      end else begin
        cur = q[0];
      end
      bus_expect(cur, es, ew, ea, ed);
      chk("mdl_stb", {31'd0, STB_O}, {31'd0, es});
      if (es) begin
        chk("mdl_we", {31'd0, WE_O}, {31'd0, ew});
        chk("mdl_add", {29'd0, ADD_O}, {29'd0, ea});
        if (ew) chk("mdl_dat", DAT_O, ed);
      end
      ack    = ack_en && es;
      e_r0   = 1'b0;
      e_r1   = 1'b0;
      set_rx = 1'b0;
      if (cur.kind == K_POLL && ack) begin
        if (lsr[0] && !m_rx_valid) begin
          e.b = 8'd0;
          e.kind = K_RD;  q.push_back(e);
          e.kind = K_CLR; q.push_back(e);
        end else if (!lsr[0] && lsr[5] && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) g = 1 - m_last;
          else g = req0_valid ? 0 : 1;
          m_last = g;
          e.kind = K_TX;
          e.b = (g == 1) ? req1_data : req0_data;
          q.push_back(e);
          for (int i = 0; i < TXG; i++) begin
            e.kind = K_IDLE; q.push_back(e);
          end
          e_r0 = (g == 0);
          e_r1 = (g == 1);
        end
      end
      chk("mdl_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
      chk("mdl_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
      chk("mdl_rx_valid", {31'd0, rx_valid}, {31'd0, m_rx_valid});
      chk("mdl_rx_data", {24'd0, rx_data}, {24'd0, m_rx_data});
      chk("mdl_init_done", {31'd0, init_done}, {31'd0, m_init});
      if (cur.kind != K_POLL && (!es || ack)) begin
        void'(q.pop_front());
        if (cur.kind == K_DIVT) m_init = 1'b1;
        if (cur.kind == K_RD)   m_rx_data = rxb;
        if (cur.kind == K_CLR)  set_rx = 1'b1;
      end
      if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
      if (set_rx) m_rx_valid = 1'b1;
    end
  end

  // ---------------- stimulus and literal checks ----------------
  initial begin
    logic [7:0] got[4];
    int         n, cnt, cnt2;
    logic       seen, r0, r1;

    // Reset values
    repeat (2) @(negedge CLK_I);
    chk("reset_add", {29'd0, ADD_O}, 32'd0);
    chk("reset_dat", DAT_O, 32'd0);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);

    // Init sequence: DIVR then DIVT then LSR polling
    @(posedge CLK_I); #1 RST_I = 1'b0;
    @(negedge CLK_I);
    chk("init_w1_add", {29'd0, ADD_O}, 32'd6);
    chk("init_w1_dat", DAT_O, 32'd2604);
    chk("init_w1_we", {31'd0, WE_O}, 32'd1);
    @(negedge CLK_I);
    chk("init_w2_add", {29'd0, ADD_O}, 32'd7);
    chk("init_w2_dat", DAT_O, 32'd2604);
    chk("init_done_early", {31'd0, init_done}, 32'd0);
    @(negedge CLK_I);
    chk("init_done_set", {31'd0, init_done}, 32'd1);
    chk("poll_add", {29'd0, ADD_O}, 32'd4);
    chk("poll_we", {31'd0, WE_O}, 32'd0);

    // Single TX from requester 0
    @(posedge CLK_I); #1;
    lsr = 8'h20; req0_valid = 1'b1; req0_data = 8'h41;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_I);
      if (req0_ready) begin seen = 1'b1; break; end
    end
    chk("tx0_ready_seen", {31'd0, seen}, 32'd1);
    @(posedge CLK_I); #1 req0_valid = 1'b0;
    @(negedge CLK_I);
    chk("tx0_ready_pulse", {31'd0, req0_ready}, 32'd0);
    chk("tx0_wr_add", {29'd0, ADD_O}, 32'd0);
    chk("tx0_wr_dat", DAT_O, 32'h41);
    chk("tx0_wr_we", {31'd0, WE_O}, 32'd1);
    @(negedge CLK_I);
    chk("tx0_guard1", {31'd0, STB_O}, 32'd0);
    @(negedge CLK_I);
    chk("tx0_guard2", {31'd0, STB_O}, 32'd0);
    @(negedge CLK_I);
    chk("tx0_repoll", {28'd0, STB_O, ADD_O}, {28'd0, 1'b1, 3'd4});

    // Both requesters valid: grants alternate, requester 1 first because
    // requester 0 won last
    @(posedge CLK_I); #1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK_I);
      if (STB_O && WE_O && ACK_I && ADD_O == 3'd0) begin
        if (n < 4) got[n] = DAT_O[7:0];
        n++;
      end
      if (n >= 4) break;
    end
    chk("alt_count", n, 4);
    chk("alt_0", {24'd0, got[0]}, 32'h22);
    chk("alt_1", {24'd0, got[1]}, 32'h11);
    chk("alt_2", {24'd0, got[2]}, 32'h22);
    chk("alt_3", {24'd0, got[3]}, 32'h11);

    // RX has priority over a waiting TX request
    @(posedge CLK_I); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h33;
    lsr = 8'h21; rxb = 8'h5A; rx_ready = 1'b0;
    seen = 1'b0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (req1_ready) cnt++;
      if (STB_O && !WE_O && ADD_O == 3'd0) begin seen = 1'b1; break; end
    end
    chk("rx_rd_seen", {31'd0, seen}, 32'd1);
    chk("rx_before_tx", cnt, 0);
    @(negedge CLK_I);
    chk("rx_clr_wr", {28'd0, WE_O, ADD_O}, {28'd0, 1'b1, 3'd4});
    chk("rx_clr_dat", DAT_O, 32'd0);
    @(negedge CLK_I);
    chk("rx_valid_set", {31'd0, rx_valid}, 32'd1);
    chk("rx_data_5a", {24'd0, rx_data}, 32'h5A);

    // Sink stalled with rs still set: no writes of any kind
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (STB_O && WE_O) cnt++;
      if (req1_ready) cnt2++;
    end
    chk("stall_no_writes", cnt, 0);
    chk("stall_no_grant", cnt2, 0);
    @(posedge CLK_I); #1 rxb = 8'hC3; rx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (rx_valid && rx_data == 8'hC3) begin seen = 1'b1; break; end
    end
    chk("rx_drain_next", {31'd0, seen}, 32'd1);
    @(posedge CLK_I); #1 lsr = 8'h20;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (req1_ready) begin seen = 1'b1; break; end
    end
    chk("tx_after_rx", {31'd0, seen}, 32'd1);
    @(posedge CLK_I); #1 req1_valid = 1'b0;
    @(negedge CLK_I);
    chk("tx_after_rx_dat", DAT_O, 32'h33);
    repeat (4) @(negedge CLK_I);

    // Reset during a stalled DATA write
    @(posedge CLK_I); #1 req0_valid = 1'b1; req0_data = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I);
      if (req0_ready) begin seen = 1'b1; break; end
    end
    chk("rst_tx_grant", {31'd0, seen}, 32'd1);
    @(posedge CLK_I); #1 ack_en = 1'b0; req0_valid = 1'b0;
    @(negedge CLK_I);
    chk("rst_tx_stalled", {28'd0, STB_O, ADD_O}, {28'd0, 1'b1, 3'd0});
    chk("rst_tx_stall_dat", DAT_O, 32'h77);
    #2 RST_I = 1'b1;
    #1 chk("rst_async_stb", {31'd0, STB_O}, 32'd0);
    @(negedge CLK_I);
    @(posedge CLK_I); #1 RST_I = 1'b0; ack_en = 1'b1;
    @(negedge CLK_I);
    chk("rst_restart_add", {29'd0, ADD_O}, 32'd6);
    chk("rst_restart_we", {31'd0, WE_O}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_I);
      if (STB_O && WE_O && ADD_O == 3'd0 && DAT_O[7:0] == 8'h77) cnt++;
    end
    chk("rst_byte_dropped", cnt, 0);

    // Randomized traffic against the model
    r0 = 1'b0; r1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK_I);
      r0 = req0_ready; r1 = req1_ready;
      @(posedge CLK_I); #1;
      if (RST_I) begin
        RST_I = 1'b0;
      end else if ($urandom_range(0, 799) == 0) begin
        RST_I = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      lsr      = 8'($urandom);
      rxb      = 8'($urandom);
      ack_en   = ($urandom_range(0, 7) != 0);
      rx_ready = ($urandom_range(0, 1) == 1);
      if (!req0_valid || r0) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_data  = 8'($urandom);
      end
      if (!req1_valid || r1) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_data  = 8'($urandom);
      end
    end
    @(negedge CLK_I);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
